// File: rtl/alu_result_drain_if.sv
// alu_result_drain_if
//   Bundle between a vector ALU result bank, the drain, and the narrow consumer.
//   slave  : the drain side (takes frames, produces beats, reports overflow)
//   master : the environment side (offers frames, consumes beats)
//   Frame side : in_valid/in_ready, result[ALUs_num], a_{greater,equal,less}_out
//   Beat side  : out_valid/out_ready, out_data, out_lane, out_flags, out_last
//   Status     : overflow (sticky dropped-frame flag)
interface alu_result_drain_if #(
   parameter int ALUs_num    = 4,
   parameter int INPUT_WIDTH = 8
);
   localparam int RW = 2*INPUT_WIDTH;
   localparam int LW = $clog2(ALUs_num);

   logic                in_valid;
   logic                in_ready;
   logic [RW-1:0]       result [ALUs_num];
   logic [ALUs_num-1:0] a_greater_out;
   logic [ALUs_num-1:0] a_equal_out;
   logic [ALUs_num-1:0] a_less_out;
   logic                out_valid;
   logic                out_ready;
   logic [RW-1:0]       out_data;
   logic [LW-1:0]       out_lane;
   logic [2:0]          out_flags;
   logic                out_last;
   logic                overflow;

   modport slave (
      input  in_valid, result, a_greater_out, a_equal_out, a_less_out, out_ready,
      output in_ready, out_valid, out_data, out_lane, out_flags, out_last, overflow
   );

   modport master (
      output in_valid, result, a_greater_out, a_equal_out, a_less_out, out_ready,
      input  in_ready, out_valid, out_data, out_lane, out_flags, out_last, overflow
   );
endinterface

// File: rtl/alu_result_drain.sv
// alu_result_drain
//   Captures one frame of ALUs_num lane results + {greater,equal,less} flags and
//   streams it out one lane per beat, ascending lane order, over valid/ready.
//   Frames offered while a frame is still being drained are dropped and set the
//   sticky overflow flag.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_result_drain_if.slave (frame input, beat output, overflow)
// Configuration macro:
//   ALU_DRAIN_SKIP_ZERO_EN : when defined, lanes whose result is zero are not
//   emitted; an all-zero frame emits a single beat for lane 0.
module alu_result_drain #(
   parameter int ALUs_num    = 4,
   parameter int INPUT_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_result_drain_if.slave  bus
);
   localparam int RW = 2*INPUT_WIDTH;
   localparam int LW = $clog2(ALUs_num);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state, state_nxt;
   logic [RW-1:0]       data_q  [ALUs_num];
   logic [2:0]          flags_q [ALUs_num];
   logic [ALUs_num-1:0] mask_q, mask_in;
   logic [LW-1:0]       ptr, last_q, first_in, last_in, next_ptr;
   logic                ovf_q;
   logic                out_valid, out_last, in_ready;
   logic                beat, capture;

   assign beat    = out_valid && bus.out_ready;
   assign capture = bus.in_valid && in_ready;

   // Lanes eligible for emission, judged on the incoming frame.
   always_comb begin
      mask_in = '0;
      for (int i = 0; i < ALUs_num; i++) begin
`ifdef ALU_DRAIN_SKIP_ZERO_EN
         mask_in[i] = |bus.result[i];
`else
         mask_in[i] = 1'b1;
`endif
      end
   end

   // First and last emitted lane of the incoming frame. An empty mask falls
   // back to lane 0 for both, giving the single all-zero beat.
   always_comb begin
      first_in = '0;
      last_in  = '0;
      for (int i = ALUs_num-1; i >= 0; i--)
         if (mask_in[i]) first_in = LW'(i);
      for (int i = 0; i < ALUs_num; i++)
         if (mask_in[i]) last_in = LW'(i);
   end

   // Next emitted lane above the current pointer in the held frame.
   always_comb begin
      next_ptr = ptr;
      for (int i = ALUs_num-1; i >= 0; i--)
         if (mask_q[i] && (i > int'(ptr))) next_ptr = LW'(i);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (capture) state_nxt = SEND;
         SEND: if (beat && out_last) state_nxt = bus.in_valid ? SEND : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: outputs. in_ready opens in SEND only on the final handshake so the
   // next frame lands with no bubble.
   always_comb begin
      out_valid = (state == SEND);
      out_last  = (state == SEND) && (ptr == last_q);
      in_ready  = (state == IDLE) || (out_valid && bus.out_ready && out_last);
   end

   // Frame register, lane pointer, sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ALUs_num; i++) begin
            data_q[i]  <= '0;
            flags_q[i] <= '0;
         end
         mask_q <= '0;
         ptr    <= '0;
         last_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (capture) begin
            for (int i = 0; i < ALUs_num; i++) begin
               data_q[i]  <= bus.result[i];
               flags_q[i] <= {bus.a_greater_out[i], bus.a_equal_out[i], bus.a_less_out[i]};
            end
            mask_q <= mask_in;
            ptr    <= first_in;
            last_q <= last_in;
         end else if (beat && !out_last) begin
            ptr <= next_ptr;
         end
         if (bus.in_valid && !in_ready) ovf_q <= 1'b1;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_last  = out_last;
   assign bus.out_data  = data_q[ptr];
   assign bus.out_lane  = ptr;
   assign bus.out_flags = flags_q[ptr];
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_alu_result_drain.sv
module tb_alu_result_drain;
   localparam int N = 4;
`ifdef ALU_DRAIN_SKIP_ZERO_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      logic [15:0] d;
      logic [1:0]  lane;
      logic [2:0]  f;
      logic        last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nvec = 0;
   int   nerr = 0;
   logic exp_ovf = 1'b0;
   beat_t sb[$];

   logic [15:0] fr_d [N];
   logic [N-1:0] fr_g, fr_e, fr_l;

   alu_result_drain_if #(.ALUs_num(N), .INPUT_WIDTH(8)) bus ();
   alu_result_drain #(.ALUs_num(N), .INPUT_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic set_frame(input logic [15:0] d0, d1, d2, d3,
                            input logic [N-1:0] g, e, l);
      fr_d[0] = d0; fr_d[1] = d1; fr_d[2] = d2; fr_d[3] = d3;
      fr_g = g; fr_e = e; fr_l = l;
      for (int i = 0; i < N; i++) bus.result[i] = fr_d[i];
      bus.a_greater_out = g; bus.a_equal_out = e; bus.a_less_out = l;
   endtask

   // Expected beats of the frame currently on the inputs.
   task automatic push_frame();
      beat_t b;
      int n = 0;
      for (int i = 0; i < N; i++) begin
         if (!SKIP || fr_d[i] != 16'h0) begin
            b.d = fr_d[i]; b.lane = 2'(i);
            b.f = {fr_g[i], fr_e[i], fr_l[i]}; b.last = 1'b0;
            sb.push_back(b); n++;
         end
      end
      if (n == 0) begin
         b.d = fr_d[0]; b.lane = 2'd0; b.f = {fr_g[0], fr_e[0], fr_l[0]}; b.last = 1'b0;
         sb.push_back(b);
      end
      sb[sb.size()-1].last = 1'b1;
   endtask

   // One clock of stimulus with scoreboard compare of the presented beat.
   task automatic cycle(input logic iv, input logic ordy);
      logic exp_vld, exp_rdy;
      @(negedge clk);
      bus.in_valid = iv; bus.out_ready = ordy;
      #2;
      exp_vld = (sb.size() != 0);
      exp_rdy = (sb.size() == 0) || (ordy && sb.size() == 1);
      nvec++;
      if (bus.out_valid !== exp_vld) begin
         nerr++; $display("FAIL out_valid got %b want %b @%0t", bus.out_valid, exp_vld, $time);
      end
      nvec++;
      if (bus.in_ready !== exp_rdy) begin
         nerr++; $display("FAIL in_ready got %b want %b @%0t", bus.in_ready, exp_rdy, $time);
      end
      nvec++;
      if (bus.overflow !== exp_ovf) begin
         nerr++; $display("FAIL overflow got %b want %b @%0t", bus.overflow, exp_ovf, $time);
      end
      if (exp_vld) begin
         nvec++;
         if (bus.out_data !== sb[0].d || bus.out_lane !== sb[0].lane ||
             bus.out_flags !== sb[0].f || bus.out_last !== sb[0].last) begin
            nerr++;
            $display("FAIL beat got d=%h lane=%0d f=%b last=%b want d=%h lane=%0d f=%b last=%b @%0t",
                     bus.out_data, bus.out_lane, bus.out_flags, bus.out_last,
                     sb[0].d, sb[0].lane, sb[0].f, sb[0].last, $time);
         end
         if (ordy) void'(sb.pop_front());
      end
      if (iv && exp_rdy) push_frame();
      if (iv && !exp_rdy) exp_ovf = 1'b1;
   endtask

   // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0,1,...
   task automatic drain(input int mode);
      int k = 0;
      while (sb.size() != 0 && k < 64) begin
         cycle(1'b0, (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3)));
         k++;
      end
      nvec++;
      if (sb.size() != 0) begin
         nerr++; $display("FAIL drain_timeout left %0d want 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      set_frame(16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 4'h0, 4'h0);
      rst_n = 1'b0;
      #12;
      nvec++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_lane !== 2'd0 ||
          bus.out_flags !== 3'b0 || bus.out_last !== 1'b0 || bus.overflow !== 1'b0) begin
         nerr++;
         $display("FAIL reset_state got v=%b d=%h lane=%0d f=%b last=%b ovf=%b want all 0",
                  bus.out_valid, bus.out_data, bus.out_lane, bus.out_flags, bus.out_last, bus.overflow);
      end
      @(negedge clk); rst_n = 1'b1;
      exp_ovf = 1'b0;
      cycle(1'b0, 1'b1);
   endtask

   task automatic test_basic();
      set_frame(16'h0010, 16'h0020, 16'h0030, 16'h0040, 4'b0001, 4'b0010, 4'b1100);
      cycle(1'b1, 1'b1);
      drain(0);
   endtask

   task automatic test_stall();
      set_frame(16'h0010, 16'h0020, 16'h0030, 16'h0040, 4'b1010, 4'b0101, 4'b0000);
      cycle(1'b1, 1'b1);
      drain(1);
   endtask

   task automatic test_back_to_back();
      set_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'b0001, 4'b0000, 4'b1110);
      cycle(1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
      set_frame(16'hA001, 16'hA002, 16'hA003, 16'hA004, 4'b1000, 4'b0100, 4'b0011);
      cycle(1'b1, 1'b1);
      nvec++;
      if (sb.size() != N) begin
         nerr++; $display("FAIL b2b_capture queued %0d want %0d", sb.size(), N);
      end
      drain(0);
   endtask

   task automatic test_overflow();
      set_frame(16'hBEEF, 16'hCAFE, 16'hF00D, 16'hD00D, 4'b0110, 4'b1001, 4'b0000);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
      set_frame(16'h9999, 16'h8888, 16'h7777, 16'h6666, 4'b1111, 4'b0000, 4'b0000);
      cycle(1'b1, 1'b0);
      nvec++;
      if (exp_ovf !== 1'b1) begin
         nerr++; $display("FAIL overflow_offer model %b want 1", exp_ovf);
      end
      drain(0);
      cycle(1'b0, 1'b1);
   endtask

   task automatic test_mid_reset();
      set_frame(16'h0101, 16'h0202, 16'h0303, 16'h0404, 4'b0000, 4'b1111, 4'b0000);
      cycle(1'b1, 1'b1);
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b1);
      @(negedge clk);
      bus.out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      nvec++;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.overflow !== 1'b0) begin
         nerr++;
         $display("FAIL mid_reset got v=%b last=%b ovf=%b want 0 0 0",
                  bus.out_valid, bus.out_last, bus.overflow);
      end
      sb.delete();
      exp_ovf = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      set_frame(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 4'b0011, 4'b0100, 4'b1000);
      cycle(1'b1, 1'b1);
      drain(0);
   endtask

   task automatic test_skip_zero();
      set_frame(16'h0000, 16'h0005, 16'h0000, 16'h0000, 4'b0010, 4'b0001, 4'b1100);
      cycle(1'b1, 1'b1);
      nvec++;
      if (sb.size() != (SKIP ? 1 : N)) begin
         nerr++; $display("FAIL skip_count queued %0d want %0d", sb.size(), SKIP ? 1 : N);
      end
      drain(0);
      set_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b1111, 4'b0000);
      cycle(1'b1, 1'b1);
      drain(1);
      cycle(1'b0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_overflow();
      test_mid_reset();
      test_skip_zero();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
